// File: rtl/instruction_sequencer.sv
// Steps each instruction through 1-3 memory cycle times driven by the TP1..TP9 pulse train.
// Optional ISEQ_INSTR_COUNT_EN builds the completed-instruction counter; otherwise instr_count is 0.
module instruction_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        tp1,
    input  logic        tp2,
    input  logic        tp3,
    input  logic        tp4,
    input  logic        tp5,
    input  logic        tp6,
    input  logic        tp7,
    input  logic        tp8,
    input  logic        tp9,
    input  logic        run,
    input  logic [14:0] mem_data,
    output logic [2:0]  opcode,
    output logic [11:0] addr,
    output logic [1:0]  mct_index,
    output logic        rd_strobe,
    output logic        wr_strobe,
    output logic        instr_done,
    output logic        tp_error,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {IDLE, EXEC, ERROR} state_t;

    state_t      state, state_nxt;
    logic [8:0]  tp;
    logic [3:0]  pnum;
    logic        any_tp, multi_tp, match, bad_pulse;
    logic [1:0]  last_mct;
    logic [3:0]  exp_pulse, exp_nxt;
    logic [14:0] next_word, next_word_nxt;
    logic [2:0]  opcode_nxt;
    logic [11:0] addr_nxt;
    logic [1:0]  mct_nxt;
    logic        rd_nxt, wr_nxt, done_nxt, err_nxt;

    function automatic logic [1:0] last_mct_of(input logic [2:0] op);
        case (op)
            3'd0:    return 2'd0;
            3'd7:    return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    assign tp        = {tp9, tp8, tp7, tp6, tp5, tp4, tp3, tp2, tp1};
    assign any_tp    = |tp;
    assign multi_tp  = (tp & (tp - 9'd1)) != 9'd0;
    assign last_mct  = last_mct_of(opcode);
    assign match     = (pnum == exp_pulse);
    assign bad_pulse = multi_tp || (any_tp && !match);

    always_comb begin
        pnum = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (tp[i]) pnum = 4'(i + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (multi_tp)          state_nxt = ERROR;
                else if (tp[0] && run) state_nxt = EXEC;
            end
            EXEC: begin
                if (bad_pulse)                                  state_nxt = ERROR;
                else if (tp[8] && mct_index >= last_mct && !run) state_nxt = IDLE;
            end
            default: state_nxt = ERROR;
        endcase
    end

    // Next values of every registered output; ERROR leaves everything frozen with strobes low.
    always_comb begin
        exp_nxt       = exp_pulse;
        next_word_nxt = next_word;
        opcode_nxt    = opcode;
        addr_nxt      = addr;
        mct_nxt       = mct_index;
        rd_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = tp_error;
        case (state)
            IDLE: begin
                if (multi_tp) begin
                    err_nxt = 1'b1;
                end else if (tp[0] && run) begin
                    exp_nxt = 4'd2;
                    mct_nxt = 2'd0;
                end
            end
            EXEC: begin
                if (bad_pulse) begin
                    err_nxt = 1'b1;
                end else if (any_tp) begin
                    exp_nxt = (pnum == 4'd9) ? 4'd1 : pnum + 4'd1;
                    rd_nxt  = tp[1];
                    wr_nxt  = tp[7] && (opcode == 3'd3 || opcode == 3'd5) && mct_index == 2'd1;
                    if (tp[5] && mct_index == last_mct) next_word_nxt = mem_data;
                    if (tp[8]) begin
                        if (mct_index < last_mct) begin
                            mct_nxt = mct_index + 2'd1;
                        end else begin
                            done_nxt   = 1'b1;
                            opcode_nxt = next_word[14:12];
                            addr_nxt   = next_word[11:0];
                            mct_nxt    = 2'd0;
                        end
                    end
                end
            end
            default: err_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_pulse  <= 4'd1;
            next_word  <= '0;
            opcode     <= '0;
            addr       <= '0;
            mct_index  <= '0;
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
            instr_done <= 1'b0;
            tp_error   <= 1'b0;
        end else begin
            exp_pulse  <= exp_nxt;
            next_word  <= next_word_nxt;
            opcode     <= opcode_nxt;
            addr       <= addr_nxt;
            mct_index  <= mct_nxt;
            rd_strobe  <= rd_nxt;
            wr_strobe  <= wr_nxt;
            instr_done <= done_nxt;
            tp_error   <= err_nxt;
        end
    end

`ifdef ISEQ_INSTR_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         instr_count <= '0;
        else if (done_nxt) instr_count <= instr_count + 16'd1;
    end
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: vector table, directed multi-cycle sequences and a
// randomized pulse train checked every cycle against a behavioural model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [8:0]  tpv = '0;
    logic [14:0] mem_data = '0;
    logic [2:0]  opcode;
    logic [11:0] addr;
    logic [1:0]  mct_index;
    logic        rd_strobe, wr_strobe, instr_done, tp_error;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int rd_seen  = 0;
    int wr_seen  = 0;
    int wr_mct   = -1;
    int last_done = 0;
    int gap      = 0;

    // Behavioural reference state
    int          m_mode;   // 0 idle, 1 executing, 2 halted on error
    int          m_exp;
    logic [2:0]  m_op;
    logic [11:0] m_addr;
    int          m_mct;
    logic [14:0] m_next;
    logic        m_rd, m_wr, m_done, m_err;
    logic [15:0] m_cnt;

    typedef struct {
        logic [8:0] tp;
        logic       run;
        logic       rd;
        logic       done;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .clk(clk), .reset(reset),
        .tp1(tpv[0]), .tp2(tpv[1]), .tp3(tpv[2]), .tp4(tpv[3]), .tp5(tpv[4]),
        .tp6(tpv[5]), .tp7(tpv[6]), .tp8(tpv[7]), .tp9(tpv[8]),
        .run(run), .mem_data(mem_data),
        .opcode(opcode), .addr(addr), .mct_index(mct_index),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .instr_done(instr_done),
        .tp_error(tp_error), .instr_count(instr_count)
    );

    function automatic logic [8:0] pulse(input int n);
        logic [8:0] one;
        one = 9'd1;
        return one << (n - 1);
    endfunction

    function automatic int mct_len(input logic [2:0] op);
        if (op == 3'd0) return 1;
        if (op == 3'd7) return 3;
        return 2;
    endfunction

    function automatic logic [36:0] dut_vec();
        return {opcode, addr, mct_index, rd_strobe, wr_strobe, instr_done, tp_error, instr_count};
    endfunction

    function automatic logic [36:0] mdl_vec();
        return {m_op, m_addr, 2'(m_mct), m_rd, m_wr, m_done, m_err, m_cnt};
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_exp = 1; m_op = '0; m_addr = '0; m_mct = 0; m_next = '0;
        m_rd = 0; m_wr = 0; m_done = 0; m_err = 0; m_cnt = '0;
    endfunction

    function automatic void model_step(input logic [8:0] t, input logic r, input logic [14:0] m);
        int n;
        int len;
        n = 0;
        m_rd = 0; m_wr = 0; m_done = 0;
        if (m_mode == 2) return;
        if ($countones(t) > 1) begin
            m_mode = 2; m_err = 1;
            return;
        end
        if (t == 9'd0) return;
        for (int i = 0; i < 9; i++) if (t[i]) n = i + 1;
        if (m_mode == 0) begin
            if (n == 1 && r) begin
                m_mode = 1; m_mct = 0; m_exp = 2;
            end
            return;
        end
        if (n != m_exp) begin
            m_mode = 2; m_err = 1;
            return;
        end
        m_exp = (n % 9) + 1;
        len = mct_len(m_op);
        if (n == 2) m_rd = 1;
        if (n == 6 && m_mct == len - 1) m_next = m;
        if (n == 8 && (m_op == 3'd3 || m_op == 3'd5) && m_mct == 1) m_wr = 1;
        if (n == 9) begin
            if (m_mct < len - 1) begin
                m_mct = m_mct + 1;
            end else begin
                m_done = 1;
`ifdef ISEQ_INSTR_COUNT_EN
                m_cnt = m_cnt + 16'd1;
`endif
                m_op = m_next[14:12];
                m_addr = m_next[11:0];
                m_mct = 0;
                if (!r) m_mode = 0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic cyc(input logic [8:0] t, input logic r, input logic [14:0] m);
        tpv = t; run = r; mem_data = m;
        @(posedge clk);
        model_step(t, r, m);
        cyc_no++;
        #1;
        if (rd_strobe) rd_seen++;
        if (wr_strobe) begin wr_seen++; wr_mct = int'(mct_index); end
        if (instr_done) begin gap = cyc_no - last_done; last_done = cyc_no; end
        check("model", dut_vec(), mdl_vec());
    endtask

    task automatic mct_pass(input logic r, input logic [14:0] m6);
        for (int n = 1; n <= 9; n++) cyc(pulse(n), r, (n == 6) ? m6 : 15'd0);
    endtask

    task automatic do_reset();
        tpv = '0; run = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_state", dut_vec(), 37'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r;
        int         p;
        logic [15:0] cnt0;

        tbl[0]  = '{9'h000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{9'h004, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{9'h001, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{9'h002, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{9'h004, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{9'h008, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{9'h010, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{9'h020, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{9'h040, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{9'h080, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{9'h100, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{9'h001, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{9'h002, 1'b1, 1'b1, 1'b0};

        #2;
        do_reset();

        // Basic sequencing, opcode 0 repeating
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].tp, tbl[i].run, 15'd0);
            check("tbl_outputs", {rd_strobe, wr_strobe, instr_done, mct_index, tp_error},
                  {tbl[i].rd, 1'b0, tbl[i].done, 2'd0, 1'b0});
        end
        for (int n = 3; n <= 9; n++) cyc(pulse(n), 1'b1, (n == 6) ? 15'h5123 : 15'd0);
        check("basic_period", gap, 9);
        check("load_opcode", opcode, 3'd5);
        check("load_addr", addr, 12'h123);

        // Two-MCT write instruction
        rd_seen = 0; wr_seen = 0; wr_mct = -1;
        mct_pass(1'b1, 15'h7456);
        mct_pass(1'b1, 15'h7456);
        check("wr_count", wr_seen, 1);
        check("wr_in_mct1", wr_mct, 1);
        check("wr_rd_count", rd_seen, 2);
        check("wr_period", gap, 18);
        check("op7_loaded", {opcode, addr}, {3'd7, 12'h456});

        // Three-MCT instruction
        rd_seen = 0; wr_seen = 0; cnt0 = instr_count;
        for (int k = 0; k < 3; k++) begin
            check("mct_step", mct_index, k);
            mct_pass(1'b1, 15'h100A);
        end
        check("op7_rd_count", rd_seen, 3);
        check("op7_wr_count", wr_seen, 0);
        check("op7_period", gap, 27);
`ifdef ISEQ_INSTR_COUNT_EN
        check("op7_count", instr_count, cnt0 + 16'd1);
`else
        check("op7_count", instr_count, 16'd0);
`endif

        // Stop request during a two-MCT instruction
        mct_pass(1'b0, 15'h30F0);
        mct_pass(1'b0, 15'h30F0);
        check("stop_period", gap, 18);
        check("stop_opcode", opcode, 3'd3);
        rd_seen = 0;
        mct_pass(1'b0, 15'd0);
        mct_pass(1'b0, 15'd0);
        check("stop_idle_rd", rd_seen, 0);

        // Reset during MCT 1 at TP4
        mct_pass(1'b1, 15'd0);
        for (int n = 1; n <= 3; n++) cyc(pulse(n), 1'b1, 15'd0);
        check("pre_reset_mct", mct_index, 2'd1);
        tpv = pulse(4);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_async", dut_vec(), 37'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_seen = 0;
        for (int n = 5; n <= 9; n++) cyc(pulse(n), 1'b1, 15'd0);
        for (int n = 2; n <= 9; n++) cyc(pulse(n), 1'b1, 15'd0);
        check("wait_tp1_rd", rd_seen, 0);
        check("wait_tp1_state", dut_vec(), 37'd0);
        mct_pass(1'b1, 15'd0);
        check("restart_rd", rd_seen, 1);
        check("restart_op", {opcode, addr}, 15'd0);

        // Randomized legal pulse train with gaps, run changes and random memory words
        r = 1'b1; p = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) r = ~r;
            if ($urandom_range(3) == 0) begin
                cyc(9'd0, r, 15'($urandom));
            end else begin
                cyc(pulse(p), r, 15'($urandom));
                p = (p % 9) + 1;
            end
        end

        // Two pulses in one cycle
        do_reset();
        cyc(pulse(1), 1'b1, 15'd0);
        cyc(pulse(2), 1'b1, 15'd0);
        check("err1_before", tp_error, 1'b0);
        cyc(pulse(3) | pulse(4), 1'b1, 15'd0);
        check("err1_flag", {tp_error, rd_strobe, wr_strobe, instr_done}, 4'b1000);
        rd_seen = 0;
        mct_pass(1'b1, 15'h5555);
        mct_pass(1'b1, 15'h5555);
        check("err1_no_rd", rd_seen, 0);
        check("err1_frozen", dut_vec(), {3'd0, 12'd0, 2'd0, 4'b0001, 16'd0});

        // Skipped pulse
        do_reset();
        for (int n = 1; n <= 3; n++) cyc(pulse(n), 1'b1, 15'd0);
        cyc(pulse(5), 1'b1, 15'd0);
        check("err2_flag", {tp_error, rd_strobe, wr_strobe, instr_done}, 4'b1000);
        rd_seen = 0;
        mct_pass(1'b1, 15'h7777);
        check("err2_no_rd", rd_seen, 0);
        check("err2_frozen", dut_vec(), {3'd0, 12'd0, 2'd0, 4'b0001, 16'd0});

        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
